reg_fifo_unit: RTL and testbench

Parametrised successor to the single-stage CGRA register unit. It provides an elastic register buffer on a fabric data channel, with configurable data width and depth and a valid/ready handshake on both sides. A MODE parameter, set at elaboration like the const/ALU config parameters, selects one of two behaviours:
- MODE 0: a DEPTH-entry FIFO.
- MODE 1: a legacy single-register pipeline stage, so existing mappings keep working.
The block sits between ALU/IO tiles on inter-PE routes.

---
 rtl/reg_fifo_unit_if.sv | 28 ++
 rtl/reg_fifo_unit.sv | 86 ++++++++
 tb/tb_reg_fifo_unit.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/reg_fifo_unit_if.sv
// Fabric data channel between PE tiles: valid/ready handshake on both sides plus occupancy status.
// The slave modport is the buffer's view; the master modport is the view of the surrounding tiles.
interface reg_fifo_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] reg_in;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] reg_out;
    logic                  out_valid;
    logic                  out_ready;
    logic [CW-1:0]         count;
    logic                  full;
    logic                  empty;

    modport slave (
        input  reg_in, in_valid, out_ready,
        output in_ready, reg_out, out_valid, count, full, empty
    );

    modport master (
        output reg_in, in_valid, out_ready,
        input  in_ready, reg_out, out_valid, count, full, empty
    );
endinterface

// File: rtl/reg_fifo_unit.sv
// Elastic register buffer for inter-PE routes: a DEPTH-entry FIFO (MODE 0) or the legacy single
// en-gated pipeline register (MODE 1). Every output is driven from registers.
module reg_fifo_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int MODE       = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    reg_fifo_unit_if.slave       bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    generate
        if (MODE == 0) begin : g_fifo
            logic [DATA_WIDTH-1:0] mem [DEPTH];
            logic [AW-1:0]         wr_ptr;
            logic [AW-1:0]         rd_ptr;
            logic [CW-1:0]         cnt;
            logic                  full_w;
            logic                  empty_w;
            logic                  push;
            logic                  pop;

            assign full_w  = (cnt == CW'(DEPTH));
            assign empty_w = (cnt == '0);
            // in_ready depends only on registered occupancy, never on out_ready.
            assign push    = en & bus.in_valid & ~full_w;
            assign pop     = en & ~empty_w & bus.out_ready;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        mem[i] <= '0;
                    end
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    cnt    <= '0;
                end else begin
                    if (push) begin
                        mem[wr_ptr] <= bus.reg_in;
                        wr_ptr      <= wr_ptr + 1'b1;
                    end
                    if (pop) begin
                        rd_ptr <= rd_ptr + 1'b1;
                    end
                    if (push && !pop) begin
                        cnt <= cnt + 1'b1;
                    end else if (pop && !push) begin
                        cnt <= cnt - 1'b1;
                    end
                end
            end

            assign bus.in_ready  = ~full_w;
            assign bus.out_valid = ~empty_w;
            assign bus.reg_out   = mem[rd_ptr];
            assign bus.count     = cnt;
            assign bus.full      = full_w;
            assign bus.empty     = empty_w;
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] data_r;
            logic                  vld_r;

            // Legacy stage: captures every enabled edge and ignores backpressure.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    data_r <= '0;
                    vld_r  <= 1'b0;
                end else if (en) begin
                    data_r <= bus.reg_in;
                    vld_r  <= bus.in_valid;
                end
            end

            assign bus.in_ready  = 1'b1;
            assign bus.out_valid = vld_r;
            assign bus.reg_out   = data_r;
            assign bus.count     = {{(CW-1){1'b0}}, vld_r};
            assign bus.full      = 1'b0;
            assign bus.empty     = ~vld_r;
        end
    endgenerate
endmodule

// File: tb/tb_reg_fifo_unit.sv
// Directed bench: a 4-deep 32-bit FIFO instance and a 16-bit legacy register instance,
// with hand-computed expectations checked by immediate assertions.
module tb_reg_fifo_unit;
    logic clk = 1'b0;
    logic rst;
    logic en0;
    logic en1;
    int   checks = 0;
    int   errors = 0;

    reg_fifo_unit_if #(.DATA_WIDTH(32), .DEPTH(4)) bus0 ();
    reg_fifo_unit_if #(.DATA_WIDTH(16), .DEPTH(4)) bus1 ();

    reg_fifo_unit #(.DATA_WIDTH(32), .DEPTH(4), .MODE(0)) dut_fifo (
        .clk (clk),
        .rst (rst),
        .en  (en0),
        .bus (bus0)
    );

    reg_fifo_unit #(.DATA_WIDTH(16), .DEPTH(4), .MODE(1)) dut_reg (
        .clk (clk),
        .rst (rst),
        .en  (en1),
        .bus (bus1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0;
        en0 = 1'b1;
        en1 = 1'b0;
        bus0.reg_in    = 32'hDEAD;
        bus0.in_valid  = 1'b1;
        bus0.out_ready = 1'b0;
        bus1.reg_in    = 16'h0;
        bus1.in_valid  = 1'b0;
        bus1.out_ready = 1'b0;

        // Reset held for two edges while a push is offered
        tick();
        tick();
        chk("rst_count", 32'(bus0.count), 32'd0);
        chk("rst_empty", 32'(bus0.empty), 32'd1);
        chk("rst_full", 32'(bus0.full), 32'd0);
        chk("rst_out_valid", 32'(bus0.out_valid), 32'd0);
        chk("rst_reg_out", bus0.reg_out, 32'd0);
        chk("rst_in_ready", 32'(bus0.in_ready), 32'd1);
        chk("rst_m1_out_valid", 32'(bus1.out_valid), 32'd0);
        chk("rst_m1_reg_out", 32'(bus1.reg_out), 32'd0);
        chk("rst_m1_count", 32'(bus1.count), 32'd0);

        rst = 1'b1;
        bus0.in_valid = 1'b0;
        tick();
        chk("idle_count", 32'(bus0.count), 32'd0);
        chk("idle_empty", 32'(bus0.empty), 32'd1);

        // Fill with out_ready low
        bus0.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus0.reg_in = 32'h11 * (i + 1);
            tick();
            if (i == 0) begin
                chk("latency_out_valid", 32'(bus0.out_valid), 32'd1);
                chk("latency_reg_out", bus0.reg_out, 32'h11);
            end
        end
        chk("fill_full", 32'(bus0.full), 32'd1);
        chk("fill_in_ready", 32'(bus0.in_ready), 32'd0);
        chk("fill_count", 32'(bus0.count), 32'd4);

        bus0.reg_in = 32'h55;
        tick();
        chk("overflow_count", 32'(bus0.count), 32'd4);
        chk("overflow_head", bus0.reg_out, 32'h11);

        // Drain
        bus0.in_valid  = 1'b0;
        bus0.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_data", bus0.reg_out, 32'h11 * (i + 1));
            chk("drain_valid", 32'(bus0.out_valid), 32'd1);
            tick();
        end
        chk("drain_empty", 32'(bus0.empty), 32'd1);
        chk("drain_count", 32'(bus0.count), 32'd0);
        tick();
        chk("underflow_count", 32'(bus0.count), 32'd0);
        chk("underflow_empty", 32'(bus0.empty), 32'd1);

        // Prime to two entries, then stream with simultaneous push/pop
        bus0.out_ready = 1'b0;
        bus0.in_valid  = 1'b1;
        bus0.reg_in    = 32'h100;
        tick();
        bus0.reg_in    = 32'h101;
        tick();
        chk("prime_count", 32'(bus0.count), 32'd2);
        bus0.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus0.reg_in = 32'h102 + 32'(i);
            chk("stream_data", bus0.reg_out, 32'h100 + 32'(i));
            tick();
            chk("stream_count", 32'(bus0.count), 32'd2);
        end

        bus0.out_ready = 1'b0;
        bus0.reg_in    = 32'h10C;
        tick();
        chk("pre_stall_count", 32'(bus0.count), 32'd3);

        // Stall with both sides requesting
        en0 = 1'b0;
        bus0.reg_in    = 32'hEE;
        bus0.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_count", 32'(bus0.count), 32'd3);
            chk("stall_head", bus0.reg_out, 32'h10A);
        end
        en0 = 1'b1;
        bus0.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("resume_data", bus0.reg_out, 32'h10A + 32'(i));
            tick();
        end
        chk("resume_empty", 32'(bus0.empty), 32'd1);

        // Reset in the middle of traffic
        bus0.out_ready = 1'b0;
        bus0.in_valid  = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            bus0.reg_in = 32'(i);
            tick();
        end
        chk("midrst_pre_count", 32'(bus0.count), 32'd3);
        rst = 1'b0;
        bus0.reg_in = 32'hAA;
        tick();
        chk("midrst_count", 32'(bus0.count), 32'd0);
        chk("midrst_out_valid", 32'(bus0.out_valid), 32'd0);
        chk("midrst_reg_out", bus0.reg_out, 32'd0);
        rst = 1'b1;
        bus0.reg_in = 32'hBB;
        tick();
        bus0.in_valid = 1'b0;
        chk("post_rst_head", bus0.reg_out, 32'hBB);
        chk("post_rst_count", 32'(bus0.count), 32'd1);

        // Legacy register mode
        en1 = 1'b1;
        bus1.reg_in    = 16'h1234;
        bus1.in_valid  = 1'b1;
        bus1.out_ready = 1'b0;
        tick();
        chk("m1_reg_out", 32'(bus1.reg_out), 32'h1234);
        chk("m1_out_valid", 32'(bus1.out_valid), 32'd1);
        chk("m1_count", 32'(bus1.count), 32'd1);
        chk("m1_empty", 32'(bus1.empty), 32'd0);
        chk("m1_full", 32'(bus1.full), 32'd0);
        chk("m1_in_ready", 32'(bus1.in_ready), 32'd1);
        en1 = 1'b0;
        bus1.reg_in   = 16'hFFFF;
        bus1.in_valid = 1'b0;
        tick();
        chk("m1_hold_data", 32'(bus1.reg_out), 32'h1234);
        chk("m1_hold_valid", 32'(bus1.out_valid), 32'd1);
        en1 = 1'b1;
        bus1.reg_in = 16'hABCD;
        tick();
        chk("m1_next_data", 32'(bus1.reg_out), 32'hABCD);
        chk("m1_next_valid", 32'(bus1.out_valid), 32'd0);
        chk("m1_next_empty", 32'(bus1.empty), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
